// File: rtl/uart_tx_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter_pkg                                                        |
// | Shared state encodings and byte width for the UART TX path.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_LOCKED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Combinational round-robin find-first: lowest set req at or above ptr.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int c_IDX_W = $clog2(N_REQ);

  // Each candidate's distance above ptr (with wrap); the nearest requester wins.
  always_comb begin
    int w_best;
    int w_dist;
    w_best = N_REQ;
    w_dist = 0;
    idx    = '0;
    any    = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = j - int'(ptr);
      if (w_dist < 0) w_dist = w_dist + N_REQ;
      if (req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        idx    = c_IDX_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter                                                            |
// | Round-robin, frame-locked sharing of one UART TX serializer by N clients.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_BURST   = 16,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*BYTE_W-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_valid,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int c_IDX_W   = $clog2(N_REQ);
  localparam int c_BURST_W = $clog2(MAX_BURST + 1);
  localparam int c_GAP_W   = $clog2(GAP_TIMEOUT);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_IDX_W-1:0]   r_owner;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_BURST_W-1:0] r_burst_cnt;
  logic [c_GAP_W-1:0]   r_gap_cnt;

  logic [BYTE_W-1:0]    w_bytes [N_REQ];
  logic [c_IDX_W-1:0]   w_pick_idx;
  logic                 w_pick_any;
  logic                 w_locked;
  logic                 w_owner_valid;
  logic                 w_accept;
  logic                 w_burst_hit;
  logic                 w_gap_hit;
  logic                 w_release;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_locked      = (r_state == ST_LOCKED);
  assign w_owner_valid = req_valid[r_owner];
  assign w_accept      = tx_valid & tx_ready;
  assign w_burst_hit   = w_accept && (r_burst_cnt == c_BURST_W'(MAX_BURST - 1));
  assign w_gap_hit     = w_locked && !w_owner_valid &&
                         (r_gap_cnt == c_GAP_W'(GAP_TIMEOUT - 1));
  // last and burst limit landing together is still one release event.
  assign w_release     = w_locked &&
                         ((w_accept && (req_last[r_owner] || w_burst_hit)) || w_gap_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick_any) w_next_state = ST_LOCKED;
      ST_LOCKED: if (w_release)  w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (w_locked) begin
      tx_valid           = w_owner_valid;
      tx_data            = w_bytes[r_owner];
      req_ready[r_owner] = tx_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
    end else if (!w_locked) begin
      if (w_pick_any) begin
        r_owner     <= w_pick_idx;
        r_burst_cnt <= '0;
        r_gap_cnt   <= '0;
      end
    end else begin
      if (w_accept) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      // Hold at the terminal count on the timeout cycle so the counter never wraps.
      if (w_owner_valid) begin
        r_gap_cnt <= '0;
      end else if (!w_gap_hit) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
      if (w_release) begin
        r_rr_ptr <= (r_owner == c_IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
    end
  end

  assign busy     = w_locked;
  assign grant_id = r_owner;

endmodule

`default_nettype wire
